// File: rtl/gb_multiport_burst.sv
// Global buffer: single-port word storage shared by one write port and NUM_CH
// independent burst-read channels, each with a 2-entry output FIFO.
module gb_multiport_burst #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned BURST_MAX = 16,
    localparam int unsigned ADDR_W   = $clog2(DEPTH),
    localparam int unsigned LEN_W    = $clog2(BURST_MAX + 1)
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_CH-1:0]        req_valid,
    output logic [NUM_CH-1:0]        req_ready,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*LEN_W-1:0]  req_len,
    output logic [NUM_CH-1:0]        rd_valid,
    input  logic [NUM_CH-1:0]        rd_ready,
    output logic [NUM_CH*DATA_W-1:0] rd_data,
    output logic [NUM_CH-1:0]        rd_last,
    output logic [NUM_CH-1:0]        busy
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q [NUM_CH];
    state_t            state_d [NUM_CH];
    logic [ADDR_W-1:0] addr_q  [NUM_CH];
    logic [ADDR_W-1:0] addr_d  [NUM_CH];
    logic [LEN_W-1:0]  icnt_q  [NUM_CH];
    logic [LEN_W-1:0]  icnt_d  [NUM_CH];
    logic [DATA_W-1:0] d0_q    [NUM_CH];
    logic [DATA_W-1:0] d0_d    [NUM_CH];
    logic [DATA_W-1:0] d1_q    [NUM_CH];
    logic [DATA_W-1:0] d1_d    [NUM_CH];
    logic [NUM_CH-1:0] v0_q, v0_d, v1_q, v1_d, l0_q, l0_d, l1_q, l1_d;
    logic [NUM_CH-1:0] ready_q, ready_d, busy_q, busy_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;

    logic [NUM_CH-1:0] elig, gnt;
    logic [CH_W-1:0]   gnt_idx, cand;
    logic [DATA_W-1:0] rdata;
    logic [LEN_W-1:0]  len_in, len_eff;
    logic              pop, push, new_last;

    // Storage write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // A channel may be granted while its FIFO has room for the returning word.
    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            elig[c] = (state_q[c] == ISSUE) && !(v0_q[c] && v1_q[c]);
        end
    end

    // Round-robin search starting at ptr_q; writes block all reads.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        cand    = '0;
        if (!wr_en) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                cand = CH_W'((32'(ptr_q) + k) % NUM_CH);
                if ((gnt == '0) && elig[cand]) begin
                    gnt[cand] = 1'b1;
                    gnt_idx   = cand;
                end
            end
        end
    end

    assign rdata = mem[addr_q[gnt_idx]];

    always_comb begin
        ptr_d    = ptr_q;
        v0_d     = v0_q;
        v1_d     = v1_q;
        l0_d     = l0_q;
        l1_d     = l1_q;
        len_in   = '0;
        len_eff  = '0;
        pop      = 1'b0;
        push     = 1'b0;
        new_last = 1'b0;
        if (gnt != '0) begin
            ptr_d = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
        end
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            state_d[c] = state_q[c];
            addr_d[c]  = addr_q[c];
            icnt_d[c]  = icnt_q[c];
            d0_d[c]    = d0_q[c];
            d1_d[c]    = d1_q[c];
            len_in     = req_len[c*LEN_W +: LEN_W];
            len_eff    = (len_in > LEN_W'(BURST_MAX)) ? LEN_W'(BURST_MAX) : len_in;
            pop        = v0_q[c] && rd_ready[c];
            push       = gnt[c];
            new_last   = (icnt_q[c] == LEN_W'(1));

            unique case (state_q[c])
                IDLE: begin
                    if (req_valid[c] && (len_in != '0)) begin
                        state_d[c] = ISSUE;
                        addr_d[c]  = req_addr[c*ADDR_W +: ADDR_W];
                        icnt_d[c]  = len_eff;
                    end
                end
                ISSUE: begin
                    if (push) begin
                        addr_d[c] = (addr_q[c] == ADDR_W'(DEPTH - 1)) ? '0 : addr_q[c] + 1'b1;
                        icnt_d[c] = icnt_q[c] - 1'b1;
                        if (new_last) begin
                            state_d[c] = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && l0_q[c]) begin
                        state_d[c] = IDLE;
                    end
                end
                default: state_d[c] = IDLE;
            endcase

            // Two-entry shift FIFO: head drives the outputs, tail fills behind it.
            if (pop) begin
                v0_d[c] = v1_q[c];
                d0_d[c] = d1_q[c];
                l0_d[c] = v1_q[c] && l1_q[c];
                v1_d[c] = 1'b0;
                l1_d[c] = 1'b0;
                if (push) begin
                    if (v1_q[c]) begin
                        v1_d[c] = 1'b1;
                        d1_d[c] = rdata;
                        l1_d[c] = new_last;
                    end else begin
                        v0_d[c] = 1'b1;
                        d0_d[c] = rdata;
                        l0_d[c] = new_last;
                    end
                end
            end else if (push) begin
                if (v0_q[c]) begin
                    v1_d[c] = 1'b1;
                    d1_d[c] = rdata;
                    l1_d[c] = new_last;
                end else begin
                    v0_d[c] = 1'b1;
                    d0_d[c] = rdata;
                    l0_d[c] = new_last;
                end
            end
            ready_d[c] = (state_d[c] == IDLE);
            busy_d[c]  = (state_d[c] != IDLE);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ptr_q   <= '0;
            v0_q    <= '0;
            v1_q    <= '0;
            l0_q    <= '0;
            l1_q    <= '0;
            ready_q <= '1;
            busy_q  <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                state_q[c] <= IDLE;
                addr_q[c]  <= '0;
                icnt_q[c]  <= '0;
                d0_q[c]    <= '0;
                d1_q[c]    <= '0;
            end
        end else begin
            ptr_q   <= ptr_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            l0_q    <= l0_d;
            l1_q    <= l1_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                state_q[c] <= state_d[c];
                addr_q[c]  <= addr_d[c];
                icnt_q[c]  <= icnt_d[c];
                d0_q[c]    <= d0_d[c];
                d1_q[c]    <= d1_d[c];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            rd_data[c*DATA_W +: DATA_W] = d0_q[c];
        end
    end

    assign rd_valid  = v0_q;
    assign rd_last   = l0_q;
    assign req_ready = ready_q;
    assign busy      = busy_q;

endmodule
